// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: processor commands and FSM states.
package dmem_pkg;

   localparam int STATE_W = 3;

   localparam logic [1:0] MEM_NONE = 2'b00;
   localparam logic [1:0] MEM_RD   = 2'b01;
   localparam logic [1:0] MEM_WR   = 2'b10;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_RUN   = 3'd3,
      S_DUMP  = 3'd4,
      S_DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous byte RAM with registered read data (read-first).
// Addresses at or beyond DEPTH ignore writes and read back as zero.
module dmem_ram #(
   parameter int ADDR_W = 19,
   parameter int DEPTH  = 20480
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]       mem [DEPTH];
   logic [IDX_W-1:0] idx;

   assign idx = addr[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (addr < ADDR_W'(DEPTH)) begin
         if (we) mem[idx] <= wdata;
         rdata <= mem[idx];
      end else begin
         rdata <= 8'h00;
      end
   end
endmodule

// File: rtl/dmem_responder.sv
// Memory-side partner of the downsampling processor: host load, processor service, result dump.
//   state | meaning
//   IDLE  | waiting for host_go
//   LOAD  | accepting IN_LEN host bytes into memory
//   START | one-cycle processor_start pulse
//   RUN   | servicing processor reads/writes until proc_status
//   DUMP  | streaming OUT_LEN result bytes to the host
//   DONE  | job finished; host_go starts another
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = 19,
   parameter int DEPTH    = 20480,
   parameter int IN_BASE  = 0,
   parameter int IN_LEN   = 16384,
   parameter int OUT_BASE = 16384,
   parameter int OUT_LEN  = 4096
) (
   input  logic                clk,
   input  logic                RST,
   input  logic                host_go,
   input  logic                in_valid,
   input  logic [7:0]          in_data,
   output logic                in_ready,
   input  logic [1:0]          proc_mem,
   input  logic [ADDR_W-1:0]   proc_addr,
   input  logic [7:0]          proc_wdata,
   output logic [7:0]          proc_rdata,
   output logic                processor_start,
   input  logic                proc_status,
   output logic                out_valid,
   output logic [7:0]          out_data,
   input  logic                out_ready,
   output logic                busy,
   output logic                done,
   output logic                addr_err,
   output logic [STATE_W-1:0]  state
);
   localparam int IN_CW  = $clog2(IN_LEN) + 1;
   localparam int OUT_CW = $clog2(OUT_LEN) + 1;
   localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] IN_BASE_A  = ADDR_W'(IN_BASE);
   localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);
   localparam logic [IN_CW-1:0]  IN_LAST    = IN_CW'(IN_LEN - 1);
   localparam logic [OUT_CW-1:0] OUT_LAST   = OUT_CW'(OUT_LEN - 1);

   state_e             st;
   logic [IN_CW-1:0]   in_cnt;
   logic [OUT_CW-1:0]  out_cnt;
   logic               out_vld;
   logic               rd_pend;
   logic [7:0]         rd_hold;
   logic               err;

   logic [ADDR_W-1:0]  ram_addr;
   logic               ram_we;
   logic [7:0]         ram_wdata;
   logic [7:0]         ram_rdata;

   logic proc_rd, proc_wr, proc_oor, dump_fire;

   assign proc_rd   = (st == S_RUN) && (proc_mem == MEM_RD);
   assign proc_wr   = (st == S_RUN) && (proc_mem == MEM_WR);
   assign proc_oor  = proc_addr >= DEPTH_A;
   assign dump_fire = out_vld && out_ready;

   // During DUMP the address runs one ahead on a transfer so the next byte is ready next cycle.
   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = in_data;
      case (st)
         S_LOAD: begin
            ram_addr = IN_BASE_A + ADDR_W'(in_cnt);
            ram_we   = in_valid;
         end
         S_RUN: begin
            ram_addr  = proc_addr;
            ram_we    = proc_wr && !proc_oor;
            ram_wdata = proc_wdata;
         end
         S_DUMP: ram_addr = OUT_BASE_A + ADDR_W'(out_cnt) + ADDR_W'(dump_fire);
         default: ram_addr = '0;
      endcase
   end

   dmem_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (RST) begin
         st      <= S_IDLE;
         in_cnt  <= '0;
         out_cnt <= '0;
         out_vld <= 1'b0;
         rd_pend <= 1'b0;
         rd_hold <= 8'h00;
         err     <= 1'b0;
      end else begin
         if (rd_pend) rd_hold <= ram_rdata;
         rd_pend <= 1'b0;
         case (st)
            S_IDLE, S_DONE: begin
               if (host_go) begin
                  st     <= S_LOAD;
                  in_cnt <= '0;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  in_cnt <= in_cnt + 1'b1;
                  if (in_cnt == IN_LAST) st <= S_START;
               end
            end
            S_START: begin
               st      <= S_RUN;
               out_cnt <= '0;
            end
            S_RUN: begin
               if ((proc_rd || proc_wr) && proc_oor) err <= 1'b1;
               // Out-of-range reads overwrite any hold capture with zero.
               if (proc_rd) begin
                  if (proc_oor) rd_hold <= 8'h00;
                  else          rd_pend <= 1'b1;
               end
               if (proc_status) st <= S_DUMP;
            end
            S_DUMP: begin
               if (dump_fire) begin
                  out_cnt <= out_cnt + 1'b1;
                  if (out_cnt == OUT_LAST) begin
                     out_vld <= 1'b0;
                     st      <= S_DONE;
                  end
               end else begin
                  out_vld <= 1'b1;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

   assign proc_rdata      = rd_pend ? ram_rdata : rd_hold;
   assign in_ready        = (st == S_LOAD);
   assign processor_start = (st == S_START);
   assign busy            = (st == S_LOAD) || (st == S_START) || (st == S_RUN) || (st == S_DUMP);
   assign done            = (st == S_DONE);
   assign out_valid       = out_vld;
   assign out_data        = out_vld ? ram_rdata : 8'h00;
   assign addr_err        = err;
   assign state           = st;
endmodule
